// File: rtl/ctrl_pipe.sv
// Control-signal pipeline ID/EX -> EX/MEM -> MEM/WB; one cycle per stage, all banks hold when en=0.
// Load-use hazards raise a combinational stall and insert one bubble; flush bubbles ID/EX and EX/MEM.
module ctrl_pipe #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic [1:0]        id_alu_op,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_2_reg,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [REG_AW-1:0] ex_dest,
  output logic              mem_branch,
  output logic              mem_jump,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_2_reg,
  output logic              mem_reg_write,
  output logic [REG_AW-1:0] mem_dest,
  output logic              wb_mem_2_reg,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_dest,
  output logic              stall
);

  // rs is only consumed by the hazard compare in ID, so it is not carried into EX.
  typedef struct packed {
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              reg_dst;
    logic              branch;
    logic              jump;
    logic              mem_read;
    logic              mem_write;
    logic              mem_2_reg;
    logic              reg_write;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic              branch;
    logic              jump;
    logic              mem_read;
    logic              mem_write;
    logic              mem_2_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dest;
  } ex_mem_t;

  typedef struct packed {
    logic              mem_2_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dest;
  } mem_wb_t;

  id_ex_t  id_ex_q, id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  always_comb begin
    id_ex_d           = '0;
    id_ex_d.alu_op    = id_alu_op;
    id_ex_d.alu_src   = id_alu_src;
    id_ex_d.reg_dst   = id_reg_dst;
    id_ex_d.branch    = id_branch;
    id_ex_d.jump      = id_jump;
    id_ex_d.mem_read  = id_mem_read;
    id_ex_d.mem_write = id_mem_write;
    id_ex_d.mem_2_reg = id_mem_2_reg;
    id_ex_d.reg_write = id_reg_write;
    id_ex_d.rt        = id_rt;
    id_ex_d.rd        = id_rd;

    ex_mem_d           = '0;
    ex_mem_d.branch    = id_ex_q.branch;
    ex_mem_d.jump      = id_ex_q.jump;
    ex_mem_d.mem_read  = id_ex_q.mem_read;
    ex_mem_d.mem_write = id_ex_q.mem_write;
    ex_mem_d.mem_2_reg = id_ex_q.mem_2_reg;
    ex_mem_d.reg_write = id_ex_q.reg_write;
    ex_mem_d.dest      = ex_dest;

    mem_wb_d           = '0;
    mem_wb_d.mem_2_reg = ex_mem_q.mem_2_reg;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.dest      = ex_mem_q.dest;
  end

  // Writes to $0 never create a dependency, so a load into rt=0 does not stall.
  assign stall = id_ex_q.mem_read && (id_ex_q.rt != '0) &&
                 ((id_ex_q.rt == id_rs) || (id_ex_q.rt == id_rt)) && !flush;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else if (en) begin
      mem_wb_q <= mem_wb_d;
      if (flush) begin
        id_ex_q  <= '0;
        ex_mem_q <= '0;
      end else begin
        ex_mem_q <= ex_mem_d;
        id_ex_q  <= stall ? '0 : id_ex_d;
      end
    end
  end

  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign ex_reg_dst    = id_ex_q.reg_dst;
  assign ex_dest       = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;

  assign mem_branch    = ex_mem_q.branch;
  assign mem_jump      = ex_mem_q.jump;
  assign mem_mem_read  = ex_mem_q.mem_read;
  assign mem_mem_write = ex_mem_q.mem_write;
  assign mem_mem_2_reg = ex_mem_q.mem_2_reg;
  assign mem_reg_write = ex_mem_q.reg_write;
  assign mem_dest      = ex_mem_q.dest;

  assign wb_mem_2_reg  = mem_wb_q.mem_2_reg;
  assign wb_reg_write  = mem_wb_q.reg_write;
  assign wb_dest       = mem_wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: vector table, hand-written flush/stall/hold/reset sequences, random run against an instruction-level model.
module tb_ctrl_pipe;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_write;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct {
    logic       en;
    logic       flush;
    instr_t     id;
    logic [1:0] e_alu;
    logic [4:0] e_exd;
    logic       e_mrw;
    logic       e_mmr;
    logic [4:0] e_md;
    logic       e_wrw;
    logic [4:0] e_wd;
    logic       e_stall;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic en = 1'b0;
  logic flush = 1'b0;
  instr_t id_in = '0;

  logic [1:0] ex_alu_op;
  logic       ex_alu_src, ex_reg_dst;
  logic [4:0] ex_dest;
  logic       mem_branch, mem_jump, mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write;
  logic [4:0] mem_dest;
  logic       wb_mem_2_reg, wb_reg_write;
  logic [4:0] wb_dest;
  logic       stall;

  int errors = 0;
  int checks = 0;

  instr_t m_ex = '0, m_mem = '0, m_wb = '0;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_AW(5)) dut (
    .clk(clk), .arst_n(arst_n), .en(en),
    .id_alu_op(id_in.alu_op), .id_reg_dst(id_in.reg_dst), .id_alu_src(id_in.alu_src),
    .id_branch(id_in.branch), .id_jump(id_in.jump), .id_mem_read(id_in.mem_read),
    .id_mem_write(id_in.mem_write), .id_mem_2_reg(id_in.mem_2_reg), .id_reg_write(id_in.reg_write),
    .id_rs(id_in.rs), .id_rt(id_in.rt), .id_rd(id_in.rd), .flush(flush),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_dest(ex_dest),
    .mem_branch(mem_branch), .mem_jump(mem_jump), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_2_reg(mem_mem_2_reg), .mem_reg_write(mem_reg_write),
    .mem_dest(mem_dest), .wb_mem_2_reg(wb_mem_2_reg), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest), .stall(stall)
  );

  function automatic instr_t mk(input logic [1:0] alu, input logic rdst, input logic asrc,
                                input logic mr, input logic mw, input logic m2r, input logic rw,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    instr_t i;
    i = '0;
    i.alu_op = alu; i.reg_dst = rdst; i.alu_src = asrc; i.mem_read = mr;
    i.mem_write = mw; i.mem_2_reg = m2r; i.reg_write = rw;
    i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic logic [27:0] obs_all();
    return {ex_alu_op, ex_alu_src, ex_reg_dst, ex_dest,
            mem_branch, mem_jump, mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write, mem_dest,
            wb_mem_2_reg, wb_reg_write, wb_dest, stall};
  endfunction

  function automatic logic [20:0] obs_short();
    return {ex_alu_op, ex_dest, mem_reg_write, mem_mem_read, mem_dest, wb_reg_write, wb_dest, stall};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each stage holds a whole instruction (zero = bubble).
  function automatic logic [4:0] dest_of(input instr_t i);
    return i.reg_dst ? i.rd : i.rt;
  endfunction

  function automatic logic model_stall();
    return m_ex.mem_read && (m_ex.rt != 0) && (m_ex.rt == id_in.rs || m_ex.rt == id_in.rt) && !flush;
  endfunction

  function automatic logic [27:0] model_obs();
    return {m_ex.alu_op, m_ex.alu_src, m_ex.reg_dst, dest_of(m_ex),
            m_mem.branch, m_mem.jump, m_mem.mem_read, m_mem.mem_write, m_mem.mem_2_reg,
            m_mem.reg_write, dest_of(m_mem),
            m_wb.mem_2_reg, m_wb.reg_write, dest_of(m_wb), model_stall()};
  endfunction

  task automatic model_edge();
    logic s;
    if (en) begin
      s = model_stall();
      m_wb = m_mem;
      if (flush) begin
        m_mem = '0;
        m_ex  = '0;
      end else begin
        m_mem = m_ex;
        m_ex  = s ? instr_t'('0) : id_in;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    en = 1'b0; flush = 1'b0; id_in = '0;
    m_ex = '0; m_mem = '0; m_wb = '0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic drive(input logic e, input logic f, input instr_t i);
    @(negedge clk);
    en = e; flush = f; id_in = i;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[9];
  instr_t R, LW, USE, NOP, LW0, Z, ADD, SW;

  initial begin
    R   = mk(2'd2, 1, 0, 0, 0, 0, 1, 5'd1, 5'd2, 5'd5);
    LW  = mk(2'd0, 0, 1, 1, 0, 1, 1, 5'd3, 5'd8, 5'd0);
    USE = mk(2'd2, 1, 0, 0, 0, 0, 1, 5'd8, 5'd9, 5'd10);
    NOP = '0;
    LW0 = mk(2'd0, 0, 1, 1, 0, 1, 1, 5'd0, 5'd0, 5'd0);
    Z   = mk(2'd2, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd3);
    ADD = mk(2'd0, 1, 0, 0, 0, 0, 1, 5'd1, 5'd2, 5'd7);
    SW  = mk(2'd0, 0, 1, 0, 1, 0, 0, 5'd8, 5'd4, 5'd0);

    //          en flush id   alu exd  mrw mmr md   wrw wd  stall
    vt[0] = '{1'b1, 1'b0, R,   2'd0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
    vt[1] = '{1'b1, 1'b0, NOP, 2'd2, 5'd5,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
    vt[2] = '{1'b1, 1'b0, LW,  2'd0, 5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 5'd0,  1'b0};
    vt[3] = '{1'b1, 1'b0, USE, 2'd0, 5'd8,  1'b0, 1'b0, 5'd0,  1'b1, 5'd5,  1'b1};
    vt[4] = '{1'b1, 1'b0, USE, 2'd0, 5'd0,  1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0};
    vt[5] = '{1'b1, 1'b0, NOP, 2'd2, 5'd10, 1'b0, 1'b0, 5'd0,  1'b1, 5'd8,  1'b0};
    vt[6] = '{1'b1, 1'b0, LW0, 2'd0, 5'd0,  1'b1, 1'b0, 5'd10, 1'b0, 5'd0,  1'b0};
    vt[7] = '{1'b1, 1'b0, Z,   2'd0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 5'd10, 1'b0};
    vt[8] = '{1'b1, 1'b0, NOP, 2'd2, 5'd3,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0};

    // Reset state, with an ID instruction that would hazard against a live load.
    id_in = USE;
    #12;
    chk("reset_outputs", {4'd0, obs_all()}, 32'd0);
    arst_n = 1'b1;

    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(vt[k].en, vt[k].flush, vt[k].id);
      chk($sformatf("vec%0d", k), {11'd0, obs_short()},
          {11'd0, vt[k].e_alu, vt[k].e_exd, vt[k].e_mrw, vt[k].e_mmr, vt[k].e_md,
           vt[k].e_wrw, vt[k].e_wd, vt[k].e_stall});
      @(posedge clk);
    end

    // Flush with SW in ID and ADD in EX; R in MEM must retire.
    do_reset();
    drive(1, 0, R);   tick();
    drive(1, 0, ADD); tick();
    drive(1, 1, SW);
    chk("flush_stall_low", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_ex_dest", {27'd0, ex_dest}, 32'd0);
    chk("flush_ex_alu_src", {31'd0, ex_alu_src}, 32'd0);
    chk("flush_mem_reg_write", {31'd0, mem_reg_write}, 32'd0);
    chk("flush_mem_dest", {27'd0, mem_dest}, 32'd0);
    chk("flush_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("flush_wb_dest", {27'd0, wb_dest}, 32'd5);
    drive(1, 0, NOP); tick();
    chk("flush_sw_gone", {31'd0, mem_mem_write}, 32'd0);
    chk("flush_add_gone", {31'd0, wb_reg_write}, 32'd0);

    // Flush wins over a live load-use hazard.
    do_reset();
    drive(1, 0, R);  tick();
    drive(1, 0, LW); tick();
    drive(1, 0, USE);
    chk("hazard_stall_high", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_masks_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("fs_ex_bubble", {23'd0, ex_alu_op, ex_alu_src, ex_reg_dst, ex_dest}, 32'd0);
    chk("fs_mem_bubble", {26'd0, mem_branch, mem_jump, mem_mem_read, mem_mem_write,
                          mem_mem_2_reg, mem_reg_write}, 32'd0);
    chk("fs_wb_retire", {26'd0, wb_reg_write, wb_dest}, {26'd0, 1'b1, 5'd5});

    // Hold for three cycles with a stall-producing state, then async reset mid-cycle.
    do_reset();
    drive(1, 0, R);  tick();
    drive(1, 0, LW); tick();
    drive(0, 0, USE);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d", k), {4'd0, obs_all()},
          {4'd0, 2'd0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,
           1'b0, 1'b0, 5'd0, 1'b1});
    end
    #2;
    arst_n = 1'b0;
    #1;
    chk("async_reset_clears", {4'd0, obs_all()}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1; en = 1'b1; flush = 1'b0; id_in = R;
    tick();
    chk("post_reset_load", {4'd0, obs_all()},
        {4'd0, 2'd2, 1'b0, 1'b1, 5'd5, 6'd0, 5'd0, 2'd0, 5'd0, 1'b0});

    // Random run against the instruction-level model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      instr_t r;
      @(negedge clk);
      r.alu_op    = 2'($urandom_range(0, 2));
      r.reg_dst   = 1'($urandom_range(0, 1));
      r.alu_src   = 1'($urandom_range(0, 1));
      r.branch    = ($urandom_range(0, 7) == 0);
      r.jump      = ($urandom_range(0, 7) == 0);
      r.mem_read  = ($urandom_range(0, 2) == 0);
      r.mem_write = ($urandom_range(0, 3) == 0);
      r.mem_2_reg = 1'($urandom_range(0, 1));
      r.reg_write = 1'($urandom_range(0, 1));
      r.rs        = 5'($urandom_range(0, 3));
      r.rt        = 5'($urandom_range(0, 3));
      r.rd        = 5'($urandom_range(0, 31));
      id_in = r;
      en    = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 7) == 0);
      #1;
      chk("random", {4'd0, obs_all()}, {4'd0, model_obs()});
      @(posedge clk);
      model_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
